// File: rtl/conv3x3_pkg.sv
// Shared encodings and width helpers for the 3x3 neighbourhood filter.
// Imported by the kernel and the top level.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_GAUSS   = 2'd0,
        MODE_BYPASS  = 2'd1,
        MODE_SHARPEN = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int ACC_W      = DEF_DATA_W + 4;

    // Accumulator width for a given sample width (16x gain needs 4 bits).
    function automatic int acc_width(input int dw);
        return dw + 4;
    endfunction

endpackage

// File: rtl/conv3x3_kernel.sv
// Single-channel 3x3 kernel: Gaussian, bypass or clamped sharpen.
// Purely combinational; the top level registers the result.
module conv3x3_kernel
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_nw,
    input  logic [DATA_W-1:0] i_n,
    input  logic [DATA_W-1:0] i_ne,
    input  logic [DATA_W-1:0] i_w,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_e,
    input  logic [DATA_W-1:0] i_sw,
    input  logic [DATA_W-1:0] i_s,
    input  logic [DATA_W-1:0] i_se,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_pix
);

    localparam int AW = acc_width(DATA_W);

    logic [AW-1:0]     w_gsum;
    logic [AW-1:0]     w_grnd;
    logic [AW-1:0]     w_sraw;
    logic [DATA_W-1:0] w_sclip;

    // Both filter sums; sharpen wraps in AW bits and is read as signed
    always_comb begin
        w_gsum = AW'(i_nw) + AW'(i_ne) + AW'(i_sw) + AW'(i_se)
               + ((AW'(i_n) + AW'(i_s) + AW'(i_w) + AW'(i_e)) << 1)
               + (AW'(i_c) << 2);
        w_grnd = w_gsum + AW'(8);
        w_sraw = AW'(5) * AW'(i_c)
               - AW'(i_n) - AW'(i_s) - AW'(i_w) - AW'(i_e);
        if (w_sraw[AW-1]) begin
            w_sclip = '0;
        end else if (|w_sraw[AW-2:DATA_W]) begin
            w_sclip = '1;
        end else begin
            w_sclip = w_sraw[DATA_W-1:0];
        end
    end

    // Mode select; the reserved encoding behaves as bypass
    always_comb begin
        o_pix = i_c;
        case (mode_e'(i_mode))
            MODE_GAUSS:   o_pix = w_grnd[AW-1:4];
            MODE_SHARPEN: o_pix = w_sclip;
            default:      o_pix = i_c;
        endcase
    end

endmodule

// File: rtl/matrix_conv3x3.sv
// 3x3 neighbourhood filter: column window, line counter, flush FSM,
// per-line mode latch and registered output.
module matrix_conv3x3
    import conv3x3_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CHANNELS  = 1,
    parameter int PIC_WIDTH = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [1:0]                 mode,
    input  logic [CHANNELS*DATA_W-1:0] din1,
    input  logic [CHANNELS*DATA_W-1:0] din2,
    input  logic [CHANNELS*DATA_W-1:0] din3,
    output logic                       valid_out,
    output logic [CHANNELS*DATA_W-1:0] dout
);

    localparam int PW = CHANNELS * DATA_W;
    localparam int CW = $clog2(PIC_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(PIC_WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2:0][PW-1:0] r_col0;
    logic [2:0][PW-1:0] r_col1;
    logic [2:0][PW-1:0] r_col2;
    logic [1:0]         r_mode;
    logic               r_req;
    logic               r_left;
    logic               r_valid;
    logic [PW-1:0]      r_dout;

    logic               w_accept;
    logic               w_flush;
    logic               w_last;
    logic [2:0][PW-1:0] w_west;
    logic [PW-1:0]      w_pix;

    assign ready_in  = (r_state != FLUSH);
    assign w_accept  = valid_in && ready_in;
    assign w_flush   = (r_state == FLUSH);
    assign w_last    = (r_cnt == LAST);
    assign valid_out = r_valid;
    assign dout      = r_dout;

    // Left edge: the centre column stands in for the missing west column
    assign w_west = r_left ? r_col1 : r_col2;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: last column of a line forces one flush cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_accept && w_last) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Window shift, column count, mode latch and output request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col0 <= '0;
            r_col1 <= '0;
            r_col2 <= '0;
            r_cnt  <= '0;
            r_mode <= 2'd0;
            r_req  <= 1'b0;
            r_left <= 1'b0;
        end else if (w_accept) begin
            r_col0 <= {din3, din2, din1};
            r_col1 <= r_col0;
            r_col2 <= r_col1;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
                r_mode <= mode;
            end
            r_req  <= (r_cnt != '0);
            r_left <= (r_cnt == CW'(1));
        end else if (w_flush) begin
            // col0 held so the last centre sees itself as its east neighbour
            r_col1 <= r_col0;
            r_col2 <= r_col1;
            r_req  <= 1'b1;
            r_left <= 1'b0;
        end else begin
            r_req  <= 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        conv3x3_kernel #(
            .DATA_W (DATA_W)
        ) u_kernel (
            .i_nw   (w_west[0][g*DATA_W +: DATA_W]),
            .i_n    (r_col1[0][g*DATA_W +: DATA_W]),
            .i_ne   (r_col0[0][g*DATA_W +: DATA_W]),
            .i_w    (w_west[1][g*DATA_W +: DATA_W]),
            .i_c    (r_col1[1][g*DATA_W +: DATA_W]),
            .i_e    (r_col0[1][g*DATA_W +: DATA_W]),
            .i_sw   (w_west[2][g*DATA_W +: DATA_W]),
            .i_s    (r_col1[2][g*DATA_W +: DATA_W]),
            .i_se   (r_col0[2][g*DATA_W +: DATA_W]),
            .i_mode (r_mode),
            .o_pix  (w_pix[g*DATA_W +: DATA_W])
        );
    end

    // Output register: one valid pulse per requested centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= r_req;
            if (r_req) begin
                r_dout <= w_pix;
            end
        end
    end

endmodule

// File: tb/tb_matrix_conv3x3.sv
// Scoreboard bench for matrix_conv3x3 (3 channels, 250-pixel lines).
// Expected pixels are queued per line; a monitor pops on valid_out.
module tb_matrix_conv3x3;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int PW = 250;
    localparam int BW = CH * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [1:0]    mode = 2'd0;
    logic [BW-1:0] din1 = '0;
    logic [BW-1:0] din2 = '0;
    logic [BW-1:0] din3 = '0;
    logic          valid_out;
    logic [BW-1:0] dout;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    matrix_conv3x3 #(
        .DATA_W    (DW),
        .CHANNELS  (CH),
        .PIC_WIDTH (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .mode      (mode),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .valid_out (valid_out),
        .dout      (dout)
    );

    function automatic logic [BW-1:0] rep(input logic [DW-1:0] v);
        return {CH{v}};
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] c, input logic [1:0] m,
                        output int waited);
        waited = 0;
        @(negedge clk);
        valid_in = 1'b1;
        din1 = a;
        din2 = b;
        din3 = c;
        mode = m;
        while (!ready_in && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL ready_stuck: ready_in=0 expected 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    // Monitor: every valid_out pops one expected pixel
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid_out) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none", dout);
                end else begin
                    chk("dout", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        int n_mark;
        logic [BW-1:0] px;
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;

        #12;
        chk("rst_dout", dout, '0);
        chk("rst_valid", BW'(valid_out), BW'(0));
        chk("rst_ready", BW'(ready_in), BW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // A: Gaussian constant 100
        for (int j = 0; j < PW; j++) exp_q.push_back(rep(8'd100));
        for (int k = 0; k < PW; k++)
            send(rep(8'd100), rep(8'd100), rep(8'd100), 2'd0, w);
        @(negedge clk);
        valid_in = 1'b0;
        chk("ready_flush", BW'(ready_in), BW'(0));
        @(negedge clk);
        chk("ready_after", BW'(ready_in), BW'(1));

        // B: Gaussian impulse 160 at row y, column 5
        for (int j = 0; j < PW; j++)
            exp_q.push_back(j == 5 ? rep(8'd40) :
                            (j == 4 || j == 6) ? rep(8'd20) : '0);
        for (int k = 0; k < PW; k++)
            send('0, (k == 5) ? rep(8'd160) : '0, '0, 2'd0, w);

        // C: left-edge replicate, Gaussian
        for (int j = 0; j < PW; j++)
            exp_q.push_back(j == 0 ? rep(8'd30) :
                            j == 1 ? rep(8'd10) : '0);
        for (int k = 0; k < PW; k++)
            send('0, (k == 0) ? rep(8'd80) : '0, '0, 2'd0, w);

        // D: same input, bypass
        for (int j = 0; j < PW; j++)
            exp_q.push_back(j == 0 ? rep(8'd80) : '0);
        for (int k = 0; k < PW; k++)
            send('0, (k == 0) ? rep(8'd80) : '0, '0, 2'd1, w);

        // E: sharpen, distinct pattern per channel
        for (int j = 0; j < PW; j++) begin
            c0 = (j == 10) ? 8'd255 : 8'd0;
            c1 = (j == 10) ? 8'd0 : 8'd255;
            exp_q.push_back({8'd130, c1, c0});
        end
        for (int k = 0; k < PW; k++) begin
            c0 = (k == 10) ? 8'd255 : 8'd0;
            c1 = (k == 10) ? 8'd0 : 8'd255;
            px = {8'd50, c1, c0};
            send({8'd10, 8'd255, 8'd0}, px, {8'd10, 8'd255, 8'd0},
                 2'd2, w);
        end
        idle(6);
        chk_int("count_5_lines", n_out, 5 * PW);

        // F/G: stalls, mid-line mode change, back-to-back lines
        n_mark = n_out;
        for (int j = 0; j < PW; j++) exp_q.push_back(rep(8'd30));
        for (int j = 0; j < PW; j++) exp_q.push_back(rep(8'd180));
        for (int k = 0; k < PW; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send('0, rep(8'd60), '0, (k >= 100) ? 2'd2 : 2'd0, w);
        end
        send('0, rep(8'd60), '0, 2'd2, w);
        chk_int("flush_stall", w, 1);
        for (int k = 1; k < PW; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send('0, rep(8'd60), '0, 2'd2, w);
        end
        idle(6);
        chk_int("count_b2b", n_out - n_mark, 2 * PW);

        // Reset mid-line at column 120
        for (int j = 0; j < PW; j++) exp_q.push_back(rep(8'd200));
        for (int k = 0; k <= 120; k++)
            send(rep(8'd200), rep(8'd200), rep(8'd200), 2'd0, w);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, '0);
        chk("arst_valid", BW'(valid_out), BW'(0));
        exp_q.delete();
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_mark = n_out;

        for (int j = 0; j < PW; j++) exp_q.push_back(rep(8'd65));
        for (int k = 0; k < PW; k++)
            send(rep(8'd40), rep(8'd100), rep(8'd20), 2'd0, w);
        idle(6);
        chk_int("count_after_rst", n_out - n_mark, PW);
        chk_int("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
